// File: rtl/mips_br_pkg.sv
// Shared definitions for the branch resolution unit: condition codes,
// the S2 payload record and the condition decode helper.
package mips_br_pkg;

    localparam int BR_WIDTH = 32;

    // Condition codes carried on in_ft (011 and 101 decode as always-taken)
    localparam logic [2:0] FT_NE  = 3'b000;
    localparam logic [2:0] FT_EQ  = 3'b001;
    localparam logic [2:0] FT_LT  = 3'b010;
    localparam logic [2:0] FT_GEZ = 3'b100;
    localparam logic [2:0] FT_LEZ = 3'b110;
    localparam logic [2:0] FT_GTZ = 3'b111;

    // Resolved branch as held in the output stage
    typedef struct packed {
        logic                taken;
        logic                mispredict;
        logic [BR_WIDTH-1:0] target;
        logic [BR_WIDTH-1:0] fallthrough;
    } s2_payload_t;

    // Branch condition for one code given the subtract flags
    function automatic logic cond_of(input logic [2:0] ft, input logic zero, input logic neg);
        logic res;
        res = 1'b1;
        case (ft)
            FT_EQ:   res = zero;
            FT_NE:   res = ~zero;
            FT_LT:   res = neg;
            FT_LEZ:  res = neg | zero;
            FT_GEZ:  res = ~neg;
            FT_GTZ:  res = ~neg & ~zero;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational compare: a - b flags and the selected branch condition.
module br_cond_eval
    import mips_br_pkg::*;
#(
    parameter int WIDTH = BR_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ft,
    output logic             zero,
    output logic             overflow,
    output logic             negative,
    output logic             cond
);

    logic [WIDTH-1:0] diff;
    logic [7:0]       cond_vec;

    // Subtract and derive signed-compare flags
    always_comb begin
        diff     = a - b;
        zero     = (diff == '0);
        overflow = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
        negative = diff[WIDTH-1] ^ overflow;
    end

    // Evaluate every condition code in parallel, then pick the requested one
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cond
            assign cond_vec[gi] = cond_of(3'(gi), zero, negative);
        end
    endgenerate

    assign cond = cond_vec[ft];

endmodule

// File: rtl/branch_resolve.sv
// Two-stage branch resolution: S1 latches the op, S2 holds the resolved
// direction/target. Optional counters enabled by BRANCH_RESOLVE_STAT_EN.
module branch_resolve
    import mips_br_pkg::*;
#(
    parameter int WIDTH = BR_WIDTH  // payload struct is sized by BR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_ft,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_offset,
    input  logic             in_pred_taken,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [WIDTH-1:0] out_target,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc
`ifdef BRANCH_RESOLVE_STAT_EN
    ,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
`endif
);

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic [2:0]       s1_ft_reg;
    logic [WIDTH-1:0] s1_pc_reg;
    logic [WIDTH-1:0] s1_offset_reg;
    logic             s1_pred_reg;

    logic             s2_valid_reg;
    s2_payload_t      s2_reg;
    s2_payload_t      s2_next;

    logic             s2_adv;
    logic             s1_load;
    logic             s2_load;
    logic             out_xfer;

    logic             cond;
    logic             flag_zero;
    logic             flag_ovf;
    logic             flag_neg;
    logic             unused_flags;

    // Handshake and advance control; flush overrides everything
    always_comb begin
        s2_adv   = ~s2_valid_reg | out_ready;
        in_ready = (~s1_valid_reg | s2_adv) & ~flush;
        s1_load  = in_valid & in_ready;
        s2_load  = s1_valid_reg & s2_adv & ~flush;
        out_valid = s2_valid_reg & ~flush;
        out_xfer  = out_valid & out_ready;
    end

    // S1 occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
        end else if (flush) begin
            s1_valid_reg <= 1'b0;
        end else if (s1_load) begin
            s1_valid_reg <= 1'b1;
        end else if (s2_adv) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // S1 payload, loaded only when an op is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s1_ft_reg     <= '0;
            s1_pc_reg     <= '0;
            s1_offset_reg <= '0;
            s1_pred_reg   <= 1'b0;
        end else if (s1_load) begin
            s1_a_reg      <= in_a;
            s1_b_reg      <= in_b;
            s1_ft_reg     <= in_ft;
            s1_pc_reg     <= in_pc;
            s1_offset_reg <= in_offset;
            s1_pred_reg   <= in_pred_taken;
        end
    end

    br_cond_eval #(
        .WIDTH    (WIDTH)
    ) u_cond (
        .a        (s1_a_reg),
        .b        (s1_b_reg),
        .ft       (s1_ft_reg),
        .zero     (flag_zero),
        .overflow (flag_ovf),
        .negative (flag_neg),
        .cond     (cond)
    );

    // Flags are folded into cond; kept visible for debug only
    assign unused_flags = ^{flag_zero, flag_ovf, flag_neg};

    // Resolved payload computed from the S1 contents
    always_comb begin
        s2_next             = '0;
        s2_next.taken       = cond;
        s2_next.mispredict  = cond ^ s1_pred_reg;
        s2_next.fallthrough = s1_pc_reg + WIDTH'(4);
        s2_next.target      = s1_pc_reg + WIDTH'(4) + (s1_offset_reg << 2);
    end

    // S2 occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
        end else if (flush) begin
            s2_valid_reg <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
        end
    end

    // S2 payload, held stable while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_reg <= '0;
        end else if (s2_load) begin
            s2_reg <= s2_next;
        end
    end

    // Output view of the S2 stage
    always_comb begin
        out_taken      = s2_reg.taken;
        out_target     = s2_reg.target;
        redirect_valid = out_xfer & s2_reg.mispredict;
        redirect_pc    = s2_reg.taken ? s2_reg.target : s2_reg.fallthrough;
    end

`ifdef BRANCH_RESOLVE_STAT_EN
    logic [31:0] stat_branches_reg;
    logic [31:0] stat_mispredicts_reg;

    // Transfer and mispredict counters, free-running and wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_reg    <= '0;
            stat_mispredicts_reg <= '0;
        end else begin
            if (out_xfer) begin
                stat_branches_reg <= stat_branches_reg + 32'd1;
            end
            if (redirect_valid) begin
                stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_reg;
    assign stat_mispredicts = stat_mispredicts_reg;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: vector table plus back-pressure,
// flush and reset sequences.
module tb_branch_resolve;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_ft;
    logic [31:0] in_pc;
    logic [31:0] in_offset;
    logic        in_pred_taken;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef BRANCH_RESOLVE_STAT_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int checks   = 0;
    int failures = 0;

    branch_resolve dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_ft          (in_ft),
        .in_pc          (in_pc),
        .in_offset      (in_offset),
        .in_pred_taken  (in_pred_taken),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_taken      (out_taken),
        .out_target     (out_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef BRANCH_RESOLVE_STAT_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ft;
        logic [31:0] pc;
        logic [31:0] off;
        logic        pred;
        logic        exp_taken;
        logic [31:0] exp_target;
        logic        exp_redir;
        logic [31:0] exp_rpc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Send one op into an empty pipe with out_ready high and check it end to end
    task automatic send_one(input vec_t v, input int idx);
        in_a = v.a; in_b = v.b; in_ft = v.ft; in_pc = v.pc;
        in_offset = v.off; in_pred_taken = v.pred; in_valid = 1'b1;
        #1;
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        check("s1_latency", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_taken", 32'(out_taken), 32'(v.exp_taken));
        check("out_target", out_target, v.exp_target);
        check("redirect_valid", 32'(redirect_valid), 32'(v.exp_redir));
        check("redirect_pc", redirect_pc, v.exp_rpc);
        $display("TXN %0d pc=%h ft=%b taken=%0d target=%h redirect=%0d rpc=%h",
                 idx, v.pc, v.ft, out_taken, out_target, redirect_valid, redirect_pc);
        @(posedge clk); #1;
        check("drained", 32'(out_valid), 32'd0);
        check("redirect_once", 32'(redirect_valid), 32'd0);
    endtask

    logic [31:0] bp_pc[3];
    vec_t        wrap_v;
    int          sent;
    int          recv;

    initial begin
        vecs[0]  = '{32'd5, 32'd5, 3'b001, 32'h100, 32'd3, 1'b0, 1'b1, 32'h110, 1'b1, 32'h110};
        vecs[1]  = '{32'h80000000, 32'd1, 3'b010, 32'h200, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h200, 1'b0, 32'h200};
        vecs[2]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 3'b010, 32'h300, 32'h10, 1'b1, 1'b0, 32'h344, 1'b1, 32'h304};
        vecs[3]  = '{32'd0, 32'd0, 3'b100, 32'h400, 32'd2, 1'b1, 1'b1, 32'h40C, 1'b0, 32'h40C};
        vecs[4]  = '{32'd0, 32'd0, 3'b111, 32'h500, 32'd1, 1'b0, 1'b0, 32'h508, 1'b0, 32'h504};
        vecs[5]  = '{32'd3, 32'd7, 3'b101, 32'h600, 32'd0, 1'b0, 1'b1, 32'h604, 1'b1, 32'h604};
        vecs[6]  = '{32'd1, 32'd2, 3'b000, 32'h10, 32'hFFFFFFFE, 1'b1, 1'b1, 32'hC, 1'b0, 32'hC};
        vecs[7]  = '{32'hFFFFFFFF, 32'd0, 3'b110, 32'h20, 32'd4, 1'b0, 1'b1, 32'h34, 1'b1, 32'h34};
        vecs[8]  = '{32'd1, 32'd0, 3'b110, 32'h30, 32'd4, 1'b0, 1'b0, 32'h44, 1'b0, 32'h34};
        vecs[9]  = '{32'd5, 32'd6, 3'b001, 32'h40, 32'd8, 1'b1, 1'b0, 32'h64, 1'b1, 32'h44};
        vecs[10] = '{32'd9, 32'd1, 3'b011, 32'h50, 32'd0, 1'b1, 1'b1, 32'h54, 1'b0, 32'h54};
        vecs[11] = '{32'hFFFFFFFE, 32'd0, 3'b100, 32'h60, 32'd0, 1'b0, 1'b0, 32'h64, 1'b0, 32'h64};
        wrap_v   = '{32'd0, 32'd0, 3'b011, 32'hFFFFFFFC, 32'd0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_ft = '0;
        in_pc = '0; in_offset = '0; in_pred_taken = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_target", out_target, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Table of single ops
        for (int i = 0; i < 12; i++) begin
            send_one(vecs[i], i);
        end

        // Back-pressure: out_ready low for three cycles while ops stream in
        bp_pc[0] = 32'h1000; bp_pc[1] = 32'h2000; bp_pc[2] = 32'h3000;
        sent = 0; recv = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid = (sent < 3);
            in_a = 32'd0; in_b = 32'd0; in_ft = 3'b011; in_offset = 32'd0;
            in_pred_taken = 1'b1;
            in_pc = (sent < 3) ? bp_pc[sent] : 32'd0;
            out_ready = (cyc >= 3);
            #1;
            if (cyc == 2) begin
                check("bp_in_ready_drop", 32'(in_ready), 32'd0);
                check("bp_accepts", 32'(sent), 32'd2);
            end
            if (redirect_valid) begin
                check("bp_no_redirect", 32'(redirect_valid), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (recv < 3) begin
                    check("bp_order", out_target, bp_pc[recv] + 32'd4);
                    $display("TXN bp %0d target=%h", recv, out_target);
                end else begin
                    check("bp_duplicate", 32'(recv), 32'd3);
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_sent", 32'(sent), 32'd3);
        check("bp_recv", 32'(recv), 32'd3);
        out_ready = 1'b1;

        // Flush with both stages full and out_ready high
        out_ready = 1'b0;
        in_a = 32'd1; in_b = 32'd1; in_ft = 3'b001; in_pred_taken = 1'b0;
        in_offset = 32'd0; in_pc = 32'h700; in_valid = 1'b1;
        @(posedge clk); #1;
        in_pc = 32'h800;
        @(posedge clk); #1;
        in_pc = 32'h900;
        flush = 1'b1; out_ready = 1'b1;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_redirect", 32'(redirect_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("post_flush_s2", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("post_flush_s1", 32'(out_valid), 32'd0);
        $display("TXN flush done");

        // Reset mid-stream with an op sitting in S2
        out_ready = 1'b0;
        in_a = 32'd2; in_b = 32'd2; in_ft = 3'b001; in_pc = 32'hA00;
        in_offset = 32'd1; in_pred_taken = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_taken", 32'(out_taken), 32'd0);
        check("arst_out_target", out_target, 32'd0);
        check("arst_redirect_pc", redirect_pc, 32'd0);
        check("arst_redirect", 32'(redirect_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        send_one(wrap_v, 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
